sdiv_seq: RTL and testbench

- Iterative signed integer divider; the inverse operation of the team's signed tree multiplier.
- Computes quotient and remainder of a WIDTH-bit two's-complement dividend by a WIDTH-bit divisor, one restoring step per clock.
- Sits beside the multiplier in the arithmetic unit and shares its operand conventions: signed, two's complement, full-width inputs.
- Uses a start/busy/done handshake so a sequencer can issue one divide at a time.

---
 rtl/sdiv_pkg.sv | 23 ++
 rtl/sdiv_step.sv | 26 ++
 rtl/sdiv_seq.sv | 138 +++++++++++++
 tb/tb_sdiv_seq.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/sdiv_pkg.sv
// Shared types and helpers for the sequential signed divider.
package sdiv_pkg;

  localparam int SDIV_WIDTH = 32;

  // Cycles from the cycle start is presented to the cycle done is high:
  // WIDTH restoring steps in CALC, one FIX cycle, then the DONE cycle.
  localparam int SDIV_LATENCY = SDIV_WIDTH + 2;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } sdiv_state_t;

  // Absolute value as an unsigned magnitude. The most-negative value maps to
  // 2^(WIDTH-1), which still fits in WIDTH unsigned bits.
  function automatic logic [SDIV_WIDTH-1:0] abs_mag(input logic [SDIV_WIDTH-1:0] v);
    return v[SDIV_WIDTH-1] ? -v : v;
  endfunction

endpackage

// File: rtl/sdiv_step.sv
// One restoring division iteration: shift in a dividend bit, trial subtract.
module sdiv_step
  import sdiv_pkg::*;
#(
  parameter int WIDTH = SDIV_WIDTH
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic             din,
  input  logic [WIDTH-1:0] dmag,
  output logic [WIDTH:0]   rem_out,
  output logic             q_bit
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] diff;

  // Trial subtract one bit wider than the shifted remainder so the borrow is
  // unambiguous; a clear top bit means the divisor fits and is kept.
  always_comb begin
    shifted = {rem_in, din};
    diff    = shifted - {2'b00, dmag};
    q_bit   = ~diff[WIDTH+1];
    rem_out = q_bit ? diff[WIDTH:0] : shifted[WIDTH:0];
  end

endmodule

// File: rtl/sdiv_seq.sv
// Iterative signed divider with start/busy/done handshake.
//
// state | meaning
// IDLE  | waiting for start; operands captured on the accepting edge
// CALC  | WIDTH restoring steps, one per clock
// FIX   | apply signs and special cases, register results
// DONE  | one-cycle done pulse, start ignored
module sdiv_seq
  import sdiv_pkg::*;
#(
  parameter int WIDTH = SDIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int               CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]    CNT_LOAD = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  sdiv_state_t      state, nstate;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   rem;
  // Holds the dividend magnitude at first; quotient bits shift in from the
  // bottom as dividend bits leave the top, so it ends as the magnitude quotient.
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] dmag;
  logic [WIDTH-1:0] dvd_orig;
  logic             q_neg, r_neg, dz_c, ovf_c;
  logic [WIDTH:0]   step_rem;
  logic             step_q;

  sdiv_step #(.WIDTH(WIDTH)) u_step (
    .rem_in (rem),
    .din    (shreg[WIDTH-1]),
    .dmag   (dmag),
    .rem_out(step_rem),
    .q_bit  (step_q)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nstate;
  end

  // Next-state and handshake outputs.
  always_comb begin
    nstate = state;
    busy   = 1'b0;
    done   = 1'b0;
    case (state)
      IDLE: if (start) nstate = CALC;
      CALC: begin
        busy = 1'b1;
        if (cnt == '0) nstate = FIX;
      end
      FIX: begin
        busy   = 1'b1;
        nstate = DONE;
      end
      DONE: begin
        done   = 1'b1;
        nstate = IDLE;
      end
      default: nstate = IDLE;
    endcase
  end

  // Operand capture, iteration datapath and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      rem         <= '0;
      shreg       <= '0;
      dmag        <= '0;
      dvd_orig    <= '0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      dz_c        <= 1'b0;
      ovf_c       <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            dmag     <= abs_mag(divisor);
            shreg    <= abs_mag(dividend);
            rem      <= '0;
            cnt      <= CNT_LOAD;
            q_neg    <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            r_neg    <= dividend[WIDTH-1];
            dvd_orig <= dividend;
            dz_c     <= (divisor == '0);
            ovf_c    <= (dividend == MOST_NEG) && (divisor == '1);
          end
        end
        CALC: begin
          rem   <= step_rem;
          shreg <= {shreg[WIDTH-2:0], step_q};
          cnt   <= cnt - CW'(1);
        end
        FIX: begin
          if (dz_c) begin
            quotient    <= '1;
            remainder   <= dvd_orig;
            div_by_zero <= 1'b1;
            overflow    <= 1'b0;
          end else if (ovf_c) begin
            quotient    <= dvd_orig;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b1;
          end else begin
            quotient    <= q_neg ? -shreg : shreg;
            remainder   <= r_neg ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sdiv_seq.sv
// Self-checking bench for sdiv_seq: directed corner cases plus random divides
// against an arithmetic reference model.
module tb_sdiv_seq;
  import sdiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] dividend, divisor;
  logic        busy, done, div_by_zero, overflow;
  logic [31:0] quotient, remainder;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] prev_q = '0;
  logic [31:0] prev_r = '0;

  sdiv_seq #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero),
    .overflow   (overflow)
  );

  // 100 MHz clock.
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Reference: plain signed arithmetic with the two special cases.
  task automatic model(input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] q, output logic [31:0] r,
                       output logic dz, output logic ov);
    int signed sa, sb;
    sa = a;
    sb = b;
    dz = 1'b0;
    ov = 1'b0;
    if (b == 32'd0) begin
      q  = 32'hFFFF_FFFF;
      r  = a;
      dz = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q  = a;
      r  = 32'd0;
      ov = 1'b1;
    end else begin
      q = 32'(sa / sb);
      r = 32'(sa % sb);
    end
  endtask

  // One divide. Start is presented in cycle 0; done is expected in cycle
  // SDIV_LATENCY. inj1/inj2 re-pulse start (50/5) in those cycles, which must
  // be ignored. rst_at asserts reset in that cycle and aborts the divide.
  task automatic do_div(input logic [31:0] a, input logic [31:0] b,
                        input int inj1, input int inj2, input int rst_at);
    logic [31:0] eq, er;
    logic        edz, eov;
    int          ndone;
    model(a, b, eq, er, edz, eov);
    @(negedge clk);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    for (int cyc = 1; cyc <= SDIV_LATENCY; cyc++) begin
      @(negedge clk);
      start    = 1'b0;
      dividend = $urandom;
      divisor  = $urandom;
      if (rst_at != 0 && cyc == rst_at + 1) begin
        rst = 1'b0;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_quot", quotient, 32'd0);
        check("rst_rem", remainder, 32'd0);
        check("rst_dz", {31'd0, div_by_zero}, 32'd0);
        check("rst_ovf", {31'd0, overflow}, 32'd0);
        ndone = 0;
        for (int k = 0; k < 40; k++) begin
          @(negedge clk);
          if (done) ndone++;
        end
        check("rst_nodone", ndone, 32'd0);
        prev_q = '0;
        prev_r = '0;
        return;
      end
      check($sformatf("busy_c%0d", cyc), {31'd0, busy}, {31'd0, cyc < SDIV_LATENCY});
      check($sformatf("done_c%0d", cyc), {31'd0, done}, {31'd0, cyc == SDIV_LATENCY});
      if (cyc == 16) begin
        check("hold_quot", quotient, prev_q);
        check("hold_rem", remainder, prev_r);
      end
      if (cyc == inj1 || cyc == inj2) begin
        start    = 1'b1;
        dividend = 32'd50;
        divisor  = 32'd5;
      end
      if (cyc == rst_at) rst = 1'b1;
    end
    check($sformatf("quot %h/%h", a, b), quotient, eq);
    check($sformatf("rem %h/%h", a, b), remainder, er);
    check($sformatf("dz %h/%h", a, b), {31'd0, div_by_zero}, {31'd0, edz});
    check($sformatf("ovf %h/%h", a, b), {31'd0, overflow}, {31'd0, eov});
    start  = 1'b0;
    prev_q = eq;
    prev_r = er;
  endtask

  initial begin
    logic [31:0] ra, rb;
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_quot", quotient, 32'd0);
    check("reset_rem", remainder, 32'd0);
    check("reset_dz", {31'd0, div_by_zero}, 32'd0);
    check("reset_ovf", {31'd0, overflow}, 32'd0);

    do_div(32'd100, 32'd7, 0, 0, 0);
    check("direct_q_100_7", quotient, 32'd14);
    check("direct_r_100_7", remainder, 32'd2);
    do_div(32'hFFFF_FF9C, 32'd7, 0, 0, 0);
    check("direct_q_m100_7", quotient, 32'hFFFF_FFF2);
    check("direct_r_m100_7", remainder, 32'hFFFF_FFFE);
    do_div(32'hFFFF_FF9C, 32'hFFFF_FFF9, 0, 0, 0);
    check("direct_q_m100_m7", quotient, 32'd14);
    check("direct_r_m100_m7", remainder, 32'hFFFF_FFFE);
    do_div(32'd7, 32'd0, 0, 0, 0);
    do_div(32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0);
    do_div(32'h8000_0000, 32'd1, 0, 0, 0);

    // Requests during busy and during the done cycle are ignored; the one
    // right after done is accepted.
    do_div(32'd100, 32'd7, 10, SDIV_LATENCY, 0);
    do_div(32'd50, 32'd5, 0, 0, 0);

    // Mid-operation reset, then a fresh divide.
    do_div(32'd100, 32'd7, 0, 0, 15);
    do_div(32'd9, 32'hFFFF_FFFE, 0, 0, 0);
    check("direct_q_9_m2", quotient, 32'hFFFF_FFFC);
    check("direct_r_9_m2", remainder, 32'd1);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 5))
        0: begin ra = $urandom; rb = 32'($signed(8'($urandom))); end
        1: begin ra = $urandom; rb = 32'd0; end
        2: begin ra = 32'h8000_0000; rb = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFF : $urandom; end
        3: begin ra = 32'($signed(16'($urandom))); rb = $urandom; end
        default: begin ra = $urandom; rb = $urandom >> $urandom_range(0, 31); end
      endcase
      do_div(ra, rb, ($urandom_range(0, 3) == 0) ? $urandom_range(1, SDIV_LATENCY) : 0, 0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
